// File: rtl/ov7670_rgb444_capture_pkg.sv
// rtl/ov7670_rgb444_capture_pkg.sv - shared types and constants for the OV7670 RGB444 capture front end
package ov7670_rgb444_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_SKIP   = 2'd3
  } cap_state_t;

  localparam int R_W       = 4;
  localparam int G_W       = 4;
  localparam int B_W       = 4;
  localparam int RGB_W     = R_W + G_W + B_W;
  localparam int CAM_D_W   = G_W + B_W;
  // pclk, vsync, href and the data byte travel through one synchroniser
  localparam int CAM_BUS_W = CAM_D_W + 3;

  localparam logic PHASE_R  = 1'b0;
  localparam logic PHASE_GB = 1'b1;

endpackage

// File: rtl/ov7670_rgb444_capture_if.sv
// rtl/ov7670_rgb444_capture_if.sv - camera byte bus in, framed RGB444 pixel stream out
interface ov7670_rgb444_capture_if
  import ov7670_rgb444_capture_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
);

  logic                        cam_pclk;
  logic                        cam_vsync;
  logic                        cam_href;
  logic [CAM_D_W-1:0]          cam_d;

  logic [RGB_W-1:0]            pix_rgb;
  logic                        pix_valid;
  logic                        line_start;
  logic                        frame_start;
  logic                        frame_done;
  logic [$clog2(H_ACTIVE)-1:0] pix_x;
  logic [$clog2(V_ACTIVE)-1:0] pix_y;

  modport master (
    input  cam_pclk, cam_vsync, cam_href, cam_d,
    output pix_rgb, pix_valid, line_start, frame_start, frame_done, pix_x, pix_y
  );

  modport slave (
    output cam_pclk, cam_vsync, cam_href, cam_d,
    input  pix_rgb, pix_valid, line_start, frame_start, frame_done, pix_x, pix_y
  );

endinterface

// File: rtl/ov7670_rgb444_capture_cdc_sync_2ff.sv
// rtl/ov7670_rgb444_capture_cdc_sync_2ff.sv - multi-bit flop-chain synchroniser with async reset
module cdc_sync_2ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/ov7670_rgb444_capture.sv
// rtl/ov7670_rgb444_capture.sv - OV7670 "xR GB" byte pairing into 12-bit pixels with framing, position and geometry checks
module ov7670_rgb444_capture
  import ov7670_rgb444_capture_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    err_clr,
  output logic                    err,
  ov7670_rgb444_capture_if.master cam
);

  localparam int XW  = $clog2(H_ACTIVE);
  localparam int YW  = $clog2(V_ACTIVE);
  // Counters need one extra code so they can reach the full line/frame size
  localparam int XCW = $clog2(H_ACTIVE + 1);
  localparam int YCW = $clog2(V_ACTIVE + 1);
  localparam logic [XCW-1:0] X_END = XCW'(H_ACTIVE);
  localparam logic [YCW-1:0] Y_END = YCW'(V_ACTIVE);

  logic [CAM_BUS_W-1:0] cam_raw;
  logic [CAM_BUS_W-1:0] cam_s;
  logic                 pclk_s;
  logic                 vsync_s;
  logic                 href_s;
  logic [CAM_D_W-1:0]   d_s;

  assign cam_raw = {cam.cam_pclk, cam.cam_vsync, cam.cam_href, cam.cam_d};

  cdc_sync_2ff #(
    .WIDTH  (CAM_BUS_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cam_raw),
    .q     (cam_s)
  );

  assign {pclk_s, vsync_s, href_s, d_s} = cam_s;

  cap_state_t       state_q, state_d;
  logic             pclk_prev_q, pclk_prev_d;
  logic             vsync_prev_q, vsync_prev_d;
  logic             href_prev_q, href_prev_d;
  logic             phase_q, phase_d;
  logic [R_W-1:0]   r_q, r_d;
  logic [XCW-1:0]   x_cnt_q, x_cnt_d;
  logic [YCW-1:0]   y_cnt_q, y_cnt_d;
  logic [RGB_W-1:0] pix_rgb_q, pix_rgb_d;
  logic             pix_valid_q, pix_valid_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic [XW-1:0]    pix_x_q, pix_x_d;
  logic [YW-1:0]    pix_y_q, pix_y_d;
  logic             err_q, err_d;

  logic byte_stb;
  logic vsync_rise;
  logic vsync_fall;
  logic line_end;
  logic err_set;

  assign byte_stb   = pclk_s & ~pclk_prev_q & href_s;
  assign vsync_rise = vsync_s & ~vsync_prev_q;
  assign vsync_fall = ~vsync_s & vsync_prev_q;
  // A frame that ends with href still high closes its last line in the same cycle
  assign line_end   = (href_prev_q & ~href_s) | (vsync_rise & href_s);

  always_comb begin
    state_d       = state_q;
    pclk_prev_d   = pclk_s;
    vsync_prev_d  = vsync_s;
    href_prev_d   = href_s;
    phase_d       = phase_q;
    r_d           = r_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    pix_rgb_d     = pix_rgb_q;
    pix_valid_d   = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    err_set       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (vsync_s) state_d = ST_VBLANK;
      end
      ST_VBLANK: begin
        if (vsync_fall) begin
          state_d = en ? ST_ACTIVE : ST_SKIP;
          x_cnt_d = '0;
          y_cnt_d = '0;
          phase_d = PHASE_R;
        end
      end
      ST_SKIP: begin
        if (vsync_rise) state_d = ST_VBLANK;
      end
      ST_ACTIVE: begin
        if (byte_stb) begin
          if (x_cnt_q == X_END || y_cnt_q == Y_END) begin
            err_set = 1'b1;
          end else if (phase_q == PHASE_R) begin
            r_d = d_s[R_W-1:0];
          end else begin
            pix_rgb_d     = {r_q, d_s};
            pix_valid_d   = 1'b1;
            line_start_d  = (x_cnt_q == '0);
            frame_start_d = (x_cnt_q == '0) && (y_cnt_q == '0);
            pix_x_d       = x_cnt_q[XW-1:0];
            pix_y_d       = y_cnt_q[YW-1:0];
            x_cnt_d       = x_cnt_q + XCW'(1);
          end
          phase_d = ~phase_q;
        end
        if (line_end) begin
          if (phase_d == PHASE_GB || x_cnt_d != X_END) err_set = 1'b1;
          x_cnt_d = '0;
          phase_d = PHASE_R;
          if (y_cnt_q != Y_END) y_cnt_d = y_cnt_q + YCW'(1);
        end
        if (vsync_rise) begin
          if (y_cnt_d != Y_END) err_set = 1'b1;
          y_cnt_d      = '0;
          frame_done_d = 1'b1;
          state_d      = ST_VBLANK;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = (err_q & ~err_clr) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pclk_prev_q   <= 1'b0;
      vsync_prev_q  <= 1'b0;
      href_prev_q   <= 1'b0;
      phase_q       <= PHASE_R;
      r_q           <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      pix_rgb_q     <= '0;
      pix_valid_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pclk_prev_q   <= pclk_prev_d;
      vsync_prev_q  <= vsync_prev_d;
      href_prev_q   <= href_prev_d;
      phase_q       <= phase_d;
      r_q           <= r_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      pix_rgb_q     <= pix_rgb_d;
      pix_valid_q   <= pix_valid_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      err_q         <= err_d;
    end
  end

  assign cam.pix_rgb     = pix_rgb_q;
  assign cam.pix_valid   = pix_valid_q;
  assign cam.line_start  = line_start_q;
  assign cam.frame_start = frame_start_q;
  assign cam.frame_done  = frame_done_q;
  assign cam.pix_x       = pix_x_q;
  assign cam.pix_y       = pix_y_q;
  assign err             = err_q;

endmodule

// File: tb/tb_ov7670_rgb444_capture.sv
// tb/tb_ov7670_rgb444_capture.sv - directed/randomised frames against a line-level reference model
module tb_ov7670_rgb444_capture;

  localparam int H = 4;
  localparam int V = 2;

  typedef struct packed {
    logic [11:0] rgb;
    logic [1:0]  x;
    logic [0:0]  y;
    logic        ls;
    logic        fs;
  } pix_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic en      = 1'b1;
  logic err_clr = 1'b0;
  logic err;

  int vectors     = 0;
  int miscompares = 0;

  pix_t got_q[$];
  pix_t exp_q[$];
  int   fd_cnt    = 0;
  int   exp_fd    = 0;
  int   pv_double = 0;
  int   stray     = 0;
  logic pv_prev   = 1'b0;

  bit armed   = 0;
  bit cap     = 0;
  bit exp_err = 0;
  bit jitter  = 0;
  int model_y = 0;

  ov7670_rgb444_capture_if #(.H_ACTIVE(H), .V_ACTIVE(V)) cam_if ();

  ov7670_rgb444_capture #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .err_clr (err_clr),
    .err     (err),
    .cam     (cam_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cam_if.pix_valid)
      got_q.push_back({cam_if.pix_rgb, cam_if.pix_x, cam_if.pix_y, cam_if.line_start, cam_if.frame_start});
    if (cam_if.pix_valid && pv_prev) pv_double++;
    if (!cam_if.pix_valid && (cam_if.line_start || cam_if.frame_start)) stray++;
    if (cam_if.frame_done) fd_cnt++;
    pv_prev = cam_if.pix_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int lo;
    int hi;
    lo = jitter ? int'($urandom_range(6, 3)) : 2;
    hi = jitter ? int'($urandom_range(6, 3)) : 2;
    cam_if.cam_d = b;
    wait_clk(lo);
    cam_if.cam_pclk = 1'b1;
    wait_clk(hi);
    cam_if.cam_pclk = 1'b0;
  endtask

  // Model: a captured line yields min(bytes/2, H) pixels unless the frame is already full
  task automatic send_line(input int nbytes, input bit fixed);
    logic [7:0] b[$];
    logic [7:0] b0;
    logic [7:0] b1;
    for (int i = 0; i < nbytes; i++) b.push_back(8'($urandom));
    if (fixed) begin
      b[0] = 8'h0A;
      b[1] = 8'hBC;
    end
    cam_if.cam_href = 1'b1;
    foreach (b[i]) send_byte(b[i]);
    wait_clk(2);
    cam_if.cam_href = 1'b0;
    wait_clk(6);
    if (cap) begin
      if (model_y < V) begin
        for (int k = 0; k < nbytes / 2 && k < H; k++) begin
          b0 = b[2*k];
          b1 = b[2*k+1];
          exp_q.push_back({b0[3:0], b1, 2'(k), 1'(model_y), (k == 0), (k == 0 && model_y == 0)});
        end
      end
      if (nbytes != 2 * H || model_y >= V) exp_err = 1;
      if (model_y < V) model_y++;
    end
  endtask

  task automatic vsync_high();
    if (cap) begin
      exp_fd++;
      if (model_y != V) exp_err = 1;
    end
    cap     = 0;
    model_y = 0;
    cam_if.cam_vsync = 1'b1;
    wait_clk(8);
    if (rst_n) armed = 1;
  endtask

  task automatic vsync_low();
    cam_if.cam_vsync = 1'b0;
    cap     = armed && en;
    model_y = 0;
    wait_clk(8);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    exp_err = 0;
    wait_clk(2);
  endtask

  task automatic rst_assert(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rgb"},   cam_if.pix_rgb,     0);
    chk({tag, "_valid"}, cam_if.pix_valid,   0);
    chk({tag, "_ls"},    cam_if.line_start,  0);
    chk({tag, "_fs"},    cam_if.frame_start, 0);
    chk({tag, "_fd"},    cam_if.frame_done,  0);
    chk({tag, "_x"},     cam_if.pix_x,       0);
    chk({tag, "_y"},     cam_if.pix_y,       0);
    chk({tag, "_err"},   err,                0);
    armed   = 0;
    cap     = 0;
    exp_err = 0;
    model_y = 0;
  endtask

  task automatic rst_release();
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, "_npix"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_pix%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_frame_done"}, fd_cnt, exp_fd);
    chk({tag, "_err"}, err, exp_err);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    cam_if.cam_pclk  = 1'b0;
    cam_if.cam_vsync = 1'b0;
    cam_if.cam_href  = 1'b0;
    cam_if.cam_d     = 8'h00;

    // 1: reset, then one full frame with a known first pixel
    rst_assert("rst0");
    rst_release();
    vsync_high();
    vsync_low();
    send_line(2 * H, 1'b1);
    send_line(2 * H, 1'b0);
    vsync_high();
    chk("t1_first_rgb", exp_q.size() > 0 ? exp_q[0].rgb : 12'h000, 12'hABC);
    check_frame("t1");

    // 2: reset released mid-frame; nothing until a full vsync high->low
    rst_assert("rst1");
    cam_if.cam_vsync = 1'b0;
    cam_if.cam_href  = 1'b1;
    send_byte(8'h55);
    send_byte(8'h66);
    rst_release();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    cam_if.cam_href = 1'b0;
    wait_clk(6);
    send_line(2 * H, 1'b0);
    check_frame("t2_pre");
    vsync_high();
    vsync_low();
    send_line(2 * H, 1'b0);
    send_line(2 * H, 1'b0);
    vsync_high();
    check_frame("t2");

    // 3: short line
    vsync_low();
    send_line(2 * (H - 1), 1'b0);
    chk("t3_err_short", err, exp_err);
    send_line(2 * H, 1'b0);
    vsync_high();
    check_frame("t3");
    pulse_err_clr();
    chk("t3_err_clr", err, exp_err);

    // 4: long line, then odd byte count
    vsync_low();
    send_line(2 * (H + 1), 1'b0);
    chk("t4_err_long", err, exp_err);
    pulse_err_clr();
    chk("t4_err_clr", err, exp_err);
    send_line(2 * H + 1, 1'b0);
    chk("t4_err_odd", err, exp_err);
    vsync_high();
    check_frame("t4");

    // 5: frame skipped by en, then resumed
    en = 1'b0;
    vsync_low();
    send_line(2 * H, 1'b0);
    send_line(2 * H, 1'b0);
    vsync_high();
    check_frame("t5_skip");
    en = 1'b1;
    vsync_low();
    send_line(2 * H, 1'b0);
    send_line(2 * H, 1'b0);
    vsync_high();
    check_frame("t5_resume");

    // 6: reset mid-line, then a jittered frame
    vsync_low();
    cam_if.cam_href = 1'b1;
    send_byte(8'h3C);
    rst_assert("rst2");
    rst_release();
    chk("t6_x_after_rst", cam_if.pix_x, 0);
    chk("t6_y_after_rst", cam_if.pix_y, 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    cam_if.cam_href = 1'b0;
    wait_clk(6);
    jitter = 1;
    send_line(2 * H, 1'b0);
    vsync_high();
    vsync_low();
    send_line(2 * H, 1'b0);
    send_line(2 * H, 1'b0);
    vsync_high();
    check_frame("t6");
    chk("pv_double", pv_double, 0);
    chk("stray_flags", stray, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
